// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter in front of the 4:1 single-bit mux.
package mux_rr_arbiter_pkg;

    localparam int         N_REQ   = 4;
    localparam logic [1:0] PTR_RST = 2'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
interface mux_rr_arbiter_if;
    import mux_rr_arbiter_pkg::*;

    // Handshake: req[i] is a level request. gnt[i] is the registered acknowledgement.
    // The owner keeps the grant by keeping req high and releases it by dropping req.
    // sel/mux data are only meaningful while busy is high.
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [1:0]       sel;
    logic             busy;
    logic             preempt;

    modport master (output req, input gnt, sel, busy, preempt);
    modport slave  (input req, output gnt, sel, busy, preempt);

endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request searching upward from ptr+1.
module rr_pick
    import mux_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       ptr,
    output logic             any,
    output logic [1:0]       idx,
    output logic [N_REQ-1:0] onehot
);

    logic [1:0] cand;

    always_comb begin
        any    = 1'b0;
        idx    = ptr;
        onehot = '0;
        cand   = ptr;
        // Offset 4 wraps back to ptr itself, so the last owner is considered last.
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ptr + 2'(k);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
        if (any) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter with bounded hold time; drives the shared 4:1 mux select.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    mux_rr_arbiter_if.slave   arb_if,
    output arb_state_e        state_o
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_e       state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic             busy_q, busy_d;
    logic             preempt_q, preempt_d;

    logic             pick_any;
    logic [1:0]       pick_idx;
    logic [N_REQ-1:0] pick_onehot;
    logic             rel_w;
    logic             expire_w;

    rr_pick u_pick (
        .req    (arb_if.req),
        .ptr    (ptr_q),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    // Release wins over expiry, so a dropping owner never produces a preempt pulse.
    assign rel_w    = !arb_if.req[sel_q];
    assign expire_w = (hold_q == HOLD_LAST) && (|(arb_if.req & ~gnt_q));

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        preempt_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_GRANT;
                    gnt_d   = pick_onehot;
                    sel_d   = pick_idx;
                    ptr_d   = pick_idx;
                    hold_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_GRANT: begin
                if (rel_w || expire_w) begin
                    state_d   = ST_IDLE;
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    preempt_d = !rel_w;
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= PTR_RST;
            hold_q    <= '0;
            gnt_q     <= '0;
            sel_q     <= 2'b00;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            preempt_q <= preempt_d;
        end
    end

    assign arb_if.gnt     = gnt_q;
    assign arb_if.sel     = sel_q;
    assign arb_if.busy    = busy_q;
    assign arb_if.preempt = preempt_q;
    assign state_o        = state_q;

endmodule
